// File: rtl/miss_fill_sequencer.sv
// Miss handler: picks a victim way, writes it back if dirty, refills the line
// beat by beat, then pulses allocateWay so the replacement policy can update.
module miss_fill_sequencer #(
    parameter int NUM_WAYS      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int OFFSET_BITS   = 4,
    parameter int BEAT_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          missValid,
    input  logic [ADDRESS_WIDTH-1:0]      missAddr,
    output logic                          missReady,
    input  logic [NUM_WAYS-1:0]           validWays,
    input  logic [NUM_WAYS-1:0]           dirtyWays,
    input  logic [NUM_WAYS-1:0]           evictionTarget,
    input  logic                          evictionReady,
    output logic [NUM_WAYS-1:0]           victimWay,
    input  logic [ADDRESS_WIDTH-1:0]      victimTagAddr,
    output logic                          memReqValid,
    input  logic                          memReqReady,
    output logic                          memReqWrite,
    output logic [ADDRESS_WIDTH-1:0]      memReqAddr,
    input  logic                          memRespValid,
    output logic                          fillWe,
    output logic [$clog2(BEAT_COUNT)-1:0] fillBeat,
    output logic [NUM_WAYS-1:0]           allocateWay,
    output logic                          protocolError
);

    localparam int                     BW        = $clog2(BEAT_COUNT);
    localparam int                     LW        = ADDRESS_WIDTH - OFFSET_BITS;
    localparam logic [BW-1:0]          LAST_BEAT = BW'(BEAT_COUNT - 1);
    localparam logic [BW-1:0]          BEAT_ONE  = BW'(1);
    localparam logic [NUM_WAYS-1:0]    WAY_ONE   = NUM_WAYS'(1);
    localparam logic [NUM_WAYS-1:0]    WAY_NONE  = {NUM_WAYS{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_WB_REQ = 3'd2,
        S_RD_REQ = 3'd3,
        S_REFILL = 3'd4,
        S_ALLOC  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_WAYS-1:0] victim_q, victim_d;
    logic [LW-1:0]       miss_line_q, miss_line_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                perr_q, perr_d;

    logic [NUM_WAYS-1:0] first_invalid_s;
    logic [NUM_WAYS-1:0] target_pick_s;
    logic                unused_bits_s;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [NUM_WAYS-1:0] lowest_one(input logic [NUM_WAYS-1:0] v);
        return v & (~v + WAY_ONE);
    endfunction

    function automatic logic is_onehot(input logic [NUM_WAYS-1:0] v);
        return (v != WAY_NONE) && ((v & (v - WAY_ONE)) == WAY_NONE);
    endfunction

    assign first_invalid_s = lowest_one(~validWays);
    assign target_pick_s   = lowest_one(evictionTarget);
    assign victimWay       = victim_q;
    assign fillBeat        = beat_q;
    assign protocolError   = perr_q;
    assign unused_bits_s   = ^{missAddr[OFFSET_BITS-1:0], victimTagAddr[OFFSET_BITS-1:0]};

    // Next-state and output decode for the miss sequence.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        miss_line_d = miss_line_q;
        beat_d      = beat_q;
        perr_d      = perr_q;
        missReady   = 1'b0;
        memReqValid = 1'b0;
        memReqWrite = 1'b0;
        memReqAddr  = {ADDRESS_WIDTH{1'b0}};
        fillWe      = 1'b0;
        allocateWay = WAY_NONE;
        case (state_q)
            S_IDLE: begin
                missReady = 1'b1;
                if (missValid) begin
                    miss_line_d = missAddr[ADDRESS_WIDTH-1:OFFSET_BITS];
                    state_d     = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                // An invalid way always wins; the policy is only consulted for a full set.
                if (!(&validWays)) begin
                    victim_d = first_invalid_s;
                    state_d  = S_RD_REQ;
                end else if (evictionReady) begin
                    if (evictionTarget == WAY_NONE) begin
                        perr_d  = 1'b1;
                        state_d = S_SELECT;
                    end else begin
                        victim_d = target_pick_s;
                        perr_d   = perr_q | ~is_onehot(evictionTarget);
                        if ((dirtyWays & target_pick_s) != WAY_NONE) begin
                            state_d = S_WB_REQ;
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_WB_REQ: begin
                memReqValid = 1'b1;
                memReqWrite = 1'b1;
                memReqAddr  = {victimTagAddr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (memReqReady) begin
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_WB_REQ;
                end
            end
            S_RD_REQ: begin
                memReqValid = 1'b1;
                memReqAddr  = {miss_line_q, {OFFSET_BITS{1'b0}}};
                if (memReqReady) begin
                    state_d = S_REFILL;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_REFILL: begin
                fillWe = memRespValid;
                if (memRespValid) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = {BW{1'b0}};
                        state_d = S_ALLOC;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_ALLOC: begin
                allocateWay = victim_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            victim_q    <= WAY_NONE;
            miss_line_q <= {LW{1'b0}};
            beat_q      <= {BW{1'b0}};
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            miss_line_q <= miss_line_d;
            beat_q      <= beat_d;
            perr_q      <= perr_d;
        end
    end

endmodule

// File: tb/tb_miss_fill_sequencer.sv
// Self-checking bench for miss_fill_sequencer: directed scenarios followed by
// randomized misses, each checked against a transaction-level expectation.
module tb_miss_fill_sequencer;

    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        missValid;
    logic [31:0] missAddr;
    logic        missReady;
    logic [3:0]  validWays, dirtyWays, evictionTarget;
    logic        evictionReady;
    logic [3:0]  victimWay;
    logic [31:0] victimTagAddr;
    logic        memReqValid, memReqReady, memReqWrite;
    logic [31:0] memReqAddr;
    logic        memRespValid, fillWe;
    logic [1:0]  fillBeat;
    logic [3:0]  allocateWay;
    logic        protocolError;

    int n_vec = 0;
    int n_err = 0;
    bit exp_perr = 1'b0;

    miss_fill_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .missValid(missValid), .missAddr(missAddr), .missReady(missReady),
        .validWays(validWays), .dirtyWays(dirtyWays),
        .evictionTarget(evictionTarget), .evictionReady(evictionReady),
        .victimWay(victimWay), .victimTagAddr(victimTagAddr),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
        .memRespValid(memRespValid), .fillWe(fillWe), .fillBeat(fillBeat),
        .allocateWay(allocateWay), .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference victim choice: lowest invalid way, else lowest set bit of the policy target.
    function automatic logic [3:0] model_victim(input logic [3:0] vw, input logic [3:0] tgt);
        logic [3:0] src;
        src = (vw == 4'hF) ? tgt : ~vw;
        for (int i = 0; i < 4; i++) begin
            if (src[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; missValid = 1'b0; missAddr = 32'h0;
        validWays = 4'h0; dirtyWays = 4'h0; evictionTarget = 4'h0; evictionReady = 1'b0;
        victimTagAddr = 32'h0; memReqReady = 1'b0; memRespValid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        exp_perr = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_missReady"}, 32'(missReady), 32'd1);
        chk({tag, "_memReqValid"}, 32'(memReqValid), 32'd0);
        chk({tag, "_memReqWrite"}, 32'(memReqWrite), 32'd0);
        chk({tag, "_memReqAddr"}, memReqAddr, 32'd0);
        chk({tag, "_fillWe"}, 32'(fillWe), 32'd0);
        chk({tag, "_fillBeat"}, 32'(fillBeat), 32'd0);
        chk({tag, "_allocateWay"}, 32'(allocateWay), 32'd0);
        chk({tag, "_victimWay"}, 32'(victimWay), 32'd0);
        chk({tag, "_protocolError"}, 32'(protocolError), 32'd0);
    endtask

    task automatic run_miss(input logic [31:0] addr, input logic [3:0] vw, input logic [3:0] dw,
                            input logic [3:0] tgt, input int edly, input logic [31:0] vtag,
                            input int wstall, input int rstall, input int maxgap,
                            input bit hold, input int abort_at);
        bit         full;
        bit         exp_wb;
        logic [3:0] exp_v;
        int         b;
        full   = (vw == 4'hF);
        exp_v  = model_victim(vw, tgt);
        exp_wb = full && ((dw & exp_v) != 4'h0);
        if (full && ($countones(tgt) != 1)) exp_perr = 1'b1;

        missValid = 1'b1; missAddr = addr; validWays = vw; dirtyWays = dw; victimTagAddr = vtag;
        memReqReady = 1'b0; memRespValid = 1'b0;
        if (full) begin
            evictionTarget = tgt;
            evictionReady  = (edly == 0);
        end else begin
            evictionTarget = 4'($urandom);
            evictionReady  = 1'($urandom_range(0, 1));
        end
        #1 chk("accept_ready", 32'(missReady), 32'd1);
        tick();
        missValid = hold;
        if (full) begin
            for (int d = 0; d < edly; d++) begin
                #1 chk("select_wait_ready", 32'(missReady), 32'd0);
                chk("select_wait_req", 32'(memReqValid), 32'd0);
                tick();
            end
            evictionReady = 1'b1;
        end
        #1 chk("select_req", 32'(memReqValid), 32'd0);
        chk("select_ready", 32'(missReady), 32'd0);
        tick();
        evictionReady = 1'b0;
        chk("victim", 32'(victimWay), 32'(exp_v));

        if (exp_wb) begin
            for (int s = 0; s <= wstall; s++) begin
                memReqReady = (s == wstall);
                #1 chk("wb_valid", 32'(memReqValid), 32'd1);
                chk("wb_write", 32'(memReqWrite), 32'd1);
                chk("wb_addr", memReqAddr, vtag & 32'hFFFF_FFF0);
                chk("wb_ready", 32'(missReady), 32'd0);
                tick();
            end
        end
        for (int s = 0; s <= rstall; s++) begin
            memReqReady = (s == rstall);
            #1 chk("rd_valid", 32'(memReqValid), 32'd1);
            chk("rd_write", 32'(memReqWrite), 32'd0);
            chk("rd_addr", memReqAddr, addr & 32'hFFFF_FFF0);
            tick();
        end
        memReqReady = 1'b0;

        b = 0;
        while (b < BC) begin
            for (int g = 0; g < int'($urandom_range(0, maxgap)); g++) begin
                memRespValid = 1'b0;
                #1 chk("gap_fillWe", 32'(fillWe), 32'd0);
                chk("gap_alloc", 32'(allocateWay), 32'd0);
                chk("gap_req", 32'(memReqValid), 32'd0);
                tick();
            end
            if (b == abort_at) begin
                reset_n = 1'b0; missValid = 1'b0; memRespValid = 1'b1;
                tick();
                reset_n = 1'b1;
                exp_perr = 1'b0;
                #1 chk_idle_outputs("abort");
                for (int k = 0; k < BC + 2; k++) begin
                    tick();
                    chk("abort_fillWe", 32'(fillWe), 32'd0);
                    chk("abort_alloc", 32'(allocateWay), 32'd0);
                    chk("abort_ready", 32'(missReady), 32'd1);
                end
                memRespValid = 1'b0;
                return;
            end
            memRespValid = 1'b1;
            #1 chk("beat_fillWe", 32'(fillWe), 32'd1);
            chk("beat_index", 32'(fillBeat), 32'(b));
            chk("beat_alloc", 32'(allocateWay), 32'd0);
            tick();
            b++;
        end
        memRespValid = 1'b0;
        #1 chk("alloc_way", 32'(allocateWay), 32'(exp_v));
        chk("alloc_ready", 32'(missReady), 32'd0);
        chk("alloc_fillWe", 32'(fillWe), 32'd0);
        tick();
        chk("post_alloc", 32'(allocateWay), 32'd0);
        chk("post_ready", 32'(missReady), 32'd1);
        chk("perr", 32'(protocolError), 32'(exp_perr));
    endtask

    initial begin
        logic [3:0]  vw, dw, tgt;
        logic [31:0] a, vt;

        do_reset();
        #1 chk_idle_outputs("reset");

        // Invalid way, minimum latency
        run_miss(32'h0000_1234, 4'b1011, 4'b0000, 4'b0000, 0, 32'h0, 0, 0, 0, 1'b0, -1);
        // Clean eviction, policy ready after 3 cycles
        run_miss(32'h0000_5670, 4'b1111, 4'b0000, 4'b0010, 3, 32'h0, 0, 0, 0, 1'b0, -1);
        // Dirty eviction with write-back stalled 2 cycles
        run_miss(32'h1111_2228, 4'b1111, 4'b0010, 4'b0010, 0, 32'hABCD_0008, 2, 1, 1, 1'b0, -1);
        // Malformed target: lowest bit chosen, error becomes sticky
        run_miss(32'h2222_3330, 4'b1111, 4'b0000, 4'b0110, 1, 32'h0, 0, 0, 0, 1'b0, -1);
        run_miss(32'h3333_4440, 4'b1111, 4'b1000, 4'b1000, 0, 32'h7777_0010, 0, 0, 0, 1'b0, -1);

        // Empty target while ready: stuck in SELECT with error raised
        do_reset();
        missValid = 1'b1; missAddr = 32'h4444_5550; validWays = 4'hF;
        evictionTarget = 4'h0; evictionReady = 1'b1;
        #1 tick();
        missValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("zero_tgt_ready", 32'(missReady), 32'd0);
            chk("zero_tgt_req", 32'(memReqValid), 32'd0);
            tick();
        end
        chk("zero_tgt_perr", 32'(protocolError), 32'd1);

        // Reset during refill after two beats
        do_reset();
        run_miss(32'h5555_6660, 4'b0111, 4'b0000, 4'b0000, 0, 32'h0, 0, 0, 0, 1'b0, 2);

        // missValid held across a whole miss, then a back-to-back second miss
        run_miss(32'h6666_7770, 4'b0001, 4'b0000, 4'b0000, 0, 32'h0, 1, 0, 1, 1'b1, -1);
        run_miss(32'h6666_8880, 4'b1111, 4'b0100, 4'b0100, 2, 32'h9999_0000, 0, 0, 0, 1'b0, -1);

        // Randomized misses
        do_reset();
        for (int n = 0; n < 30; n++) begin
            vw  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            dw  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                tgt = 4'($urandom);
                if (tgt == 4'h0) tgt = 4'h5;
            end else begin
                tgt = 4'b0001 << $urandom_range(0, 3);
            end
            a  = $urandom;
            vt = $urandom;
            run_miss(a, vw, dw, tgt, int'($urandom_range(0, 3)), vt,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2,
                     1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
